// File: rtl/comb_sched_pkg.sv
// Shared types and helpers for the comb-stage sequencer.
`default_nettype none

package comb_sched_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   localparam int C_LAT_DEF   = 4;
   localparam int CAT_LAT_DEF = 3;
   localparam int TOTAL_LAT   = 1 + C_LAT_DEF + 1;

   function automatic int f_cw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/comb_hist_ram.sv
// Per-channel history store: simple dual-port, read-first, registered read.
`default_nettype none

module comb_hist_ram #(
   parameter int DEPTH = 256,
   parameter int DW    = 48,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;

   // No reset on the array or read register so this maps onto block RAM.
   always_ff @(posedge clk) begin
      r_rdata <= r_mem[i_raddr];
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/comb_sched_m256.sv
// Sequencer for the time-multiplexed comb stage: history, c/concat skew, result tagging.
// Optional framing check enabled by defining COMB_SCHED_SYNC_CHK_EN.
`default_nettype none

module comb_sched_m256
   import comb_sched_pkg::*;
#(
   parameter  int NUM_CHAN = 256,
   parameter  int DW       = 48,
   parameter  int C_LAT    = 4,
   parameter  int CAT_LAT  = 3,
   localparam int CW       = f_cw(NUM_CHAN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   input  logic          s_first,
   input  logic          clr_req,
   output logic [DW-1:0] dsp_c,
   output logic [DW-1:0] dsp_concat,
   input  logic [DW-1:0] p,
   output logic          m_valid,
   output logic [CW-1:0] m_chan,
   output logic [DW-1:0] m_data,
   output logic          busy,
   output logic          sync_err
);

   localparam int          LAT  = 1 + C_LAT + 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_CHAN - 1);

   if ((C_LAT - CAT_LAT) != 1 || NUM_CHAN < 2) begin : g_param_chk
      $error("comb_sched_m256: illegal parameter combination");
   end

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_clr_addr, w_clr_addr_nxt;
   logic [CW-1:0] r_chan_cnt, w_chan_nxt, w_chan_use, w_chan_inc;
   logic          w_accept;
   logic          w_we;
   logic [CW-1:0] w_waddr;
   logic [DW-1:0] w_wdata;
   logic [DW-1:0] w_rdata;
   logic          r_acc_d1;
   logic [DW-1:0] r_c, r_cat, r_mdata;
   logic [LAT-1:0] r_vpipe;
   logic [CW-1:0] r_cpipe [LAT];

   assign w_accept   = s_valid && (r_state == ST_RUN);
   assign w_chan_inc = (w_chan_use == LAST) ? '0 : w_chan_use + 1'b1;

`ifdef COMB_SCHED_SYNC_CHK_EN
   logic r_sync_err;
   // A sample flagged first is realigned to channel 0 and counting resumes from there.
   assign w_chan_use = s_first ? '0 : r_chan_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync_err <= 1'b0;
      end else if (clr_req) begin
         r_sync_err <= 1'b0;
      end else if (w_accept && (s_first != (r_chan_cnt == '0))) begin
         r_sync_err <= 1'b1;
      end
   end

   assign sync_err = r_sync_err;
`else
   logic w_unused_first;
   assign w_unused_first = s_first;
   assign w_chan_use     = r_chan_cnt;
   assign sync_err       = 1'b0;
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_clr_addr_nxt = r_clr_addr;
      w_chan_nxt     = r_chan_cnt;
      w_we           = 1'b0;
      w_waddr        = r_clr_addr;
      w_wdata        = '0;
      s_ready        = 1'b0;
      busy           = 1'b1;
      case (r_state)
         ST_CLEAR: begin
            w_we = 1'b1;
            if (clr_req) begin
               w_clr_addr_nxt = '0;
            end else if (r_clr_addr == LAST) begin
               w_clr_addr_nxt = '0;
               w_state_nxt    = ST_RUN;
            end else begin
               w_clr_addr_nxt = r_clr_addr + 1'b1;
            end
         end
         ST_RUN: begin
            s_ready = 1'b1;
            busy    = 1'b0;
            if (w_accept) begin
               w_we       = 1'b1;
               w_waddr    = w_chan_use;
               w_wdata    = s_data;
               w_chan_nxt = w_chan_inc;
            end
            // The sample accepted alongside clr_req has already been launched.
            if (clr_req) begin
               w_state_nxt    = ST_CLEAR;
               w_clr_addr_nxt = '0;
               w_chan_nxt     = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_CLEAR;
         r_clr_addr <= '0;
         r_chan_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_addr <= w_clr_addr_nxt;
         r_chan_cnt <= w_chan_nxt;
      end
   end

   comb_hist_ram #(
      .DEPTH (NUM_CHAN),
      .DW    (DW),
      .AW    (CW)
   ) u_hist (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_chan_use),
      .o_rdata (w_rdata)
   );

   // concat trails c by one cycle so both operands meet inside the datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc_d1 <= 1'b0;
         r_c      <= '0;
         r_cat    <= '0;
         r_mdata  <= '0;
         r_vpipe  <= '0;
         for (int i = 0; i < LAT; i++) begin
            r_cpipe[i] <= '0;
         end
      end else begin
         r_acc_d1 <= w_accept;
         if (w_accept) begin
            r_c <= s_data;
         end
         if (r_acc_d1) begin
            r_cat <= w_rdata;
         end
         r_mdata    <= p;
         r_vpipe    <= {r_vpipe[LAT-2:0], w_accept};
         r_cpipe[0] <= w_chan_use;
         for (int i = 1; i < LAT; i++) begin
            r_cpipe[i] <= r_cpipe[i-1];
         end
      end
   end

   assign dsp_c      = r_c;
   assign dsp_concat = r_cat;
   assign m_valid    = r_vpipe[LAT-1];
   assign m_chan     = r_cpipe[LAT-1];
   assign m_data     = r_mdata;

endmodule

`default_nettype wire

// File: tb/tb_comb_sched_m256.sv
// Scoreboard bench for comb_sched_m256 with a behavioural comb datapath model.
`default_nettype none

module tb_comb_sched_m256;

   localparam int N  = 256;
   localparam int DW = 48;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_data = '0;
   logic          s_first = 1'b0;
   logic          clr_req = 1'b0;
   logic [DW-1:0] dsp_c, dsp_concat, p;
   logic          m_valid;
   logic [CW-1:0] m_chan;
   logic [DW-1:0] m_data;
   logic          busy;
   logic          sync_err;

   comb_sched_m256 dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_first    (s_first),
      .clr_req    (clr_req),
      .dsp_c      (dsp_c),
      .dsp_concat (dsp_concat),
      .p          (p),
      .m_valid    (m_valid),
      .m_chan     (m_chan),
      .m_data     (m_data),
      .busy       (busy),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   // Comb datapath: c needs 4 cycles, concat 3, to reach p.
   logic [DW-1:0] c_sh [4];
   logic [DW-1:0] cat_sh [3];
   initial begin
      for (int i = 0; i < 4; i++) c_sh[i] = '0;
      for (int i = 0; i < 3; i++) cat_sh[i] = '0;
   end
   always @(posedge clk) begin
      c_sh[0]   <= dsp_c;
      c_sh[1]   <= c_sh[0];
      c_sh[2]   <= c_sh[1];
      c_sh[3]   <= c_sh[2];
      cat_sh[0] <= dsp_concat;
      cat_sh[1] <= cat_sh[0];
      cat_sh[2] <= cat_sh[1];
   end
   assign p = c_sh[3] - cat_sh[2];

   typedef struct packed {
      logic [CW-1:0] ch;
      logic [DW-1:0] d;
   } exp_t;

   exp_t          sb_q[$];
   logic [DW-1:0] mdl_hist [N];
   int            mdl_chan;
   logic          mdl_err;
   int            n_tests = 0;
   int            n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mdl_reset();
      for (int i = 0; i < N; i++) mdl_hist[i] = '0;
      mdl_chan = 0;
      mdl_err  = 1'b0;
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic send(input logic [DW-1:0] d, input logic first, input logic clr, input logic v);
      logic acc;
      int   ch;
      exp_t e;
      s_valid = v;
      s_data  = d;
      s_first = first;
      clr_req = clr;
      acc     = v && s_ready;
      if (acc) begin
         ch = mdl_chan;
`ifdef COMB_SCHED_SYNC_CHK_EN
         if (first != (mdl_chan == 0)) mdl_err = 1'b1;
         if (first) ch = 0;
`endif
         e.ch = CW'(ch);
         e.d  = d - mdl_hist[ch];
         sb_q.push_back(e);
         mdl_hist[ch] = d;
         mdl_chan     = (ch + 1) % N;
      end
      if (clr) begin
         for (int i = 0; i < N; i++) mdl_hist[i] = '0;
         mdl_chan = 0;
         mdl_err  = 1'b0;
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_first = 1'b0;
      clr_req = 1'b0;
      if (acc) begin
         chk("dsp_c", 64'(dsp_c), 64'(d));
         chk("sync_err", 64'(sync_err), 64'(mdl_err));
      end
   endtask

   task automatic wait_clear();
      int cnt = 0;
      int bad = 0;
      while (!s_ready && cnt < 1000) begin
         cnt++;
         if (!busy) bad++;
         @(negedge clk);
      end
      chk("clear_len", 64'(cnt), 64'(N));
      chk("busy_in_clear", 64'(bad), 64'd0);
      chk("busy_run", 64'(busy), 64'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && m_valid) begin
         if (sb_q.size() == 0) begin
            chk("spurious_m_valid", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("m_chan", 64'(m_chan), 64'(e.ch));
            chk("m_data", 64'(m_data), 64'(e.d));
         end
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
      chk({tag, "_m_chan"}, 64'(m_chan), 64'd0);
      chk({tag, "_m_data"}, 64'(m_data), 64'd0);
      chk({tag, "_dsp_c"}, 64'(dsp_c), 64'd0);
      chk({tag, "_dsp_concat"}, 64'(dsp_concat), 64'd0);
      chk({tag, "_sync_err"}, 64'(sync_err), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] rv;
      mdl_reset();
      #2;
      chk_reset_vals("por");

      @(negedge clk);
      rst = 1'b0;
      wait_clear();

      // Two gapless frames: k+1 then 3(k+1)
      for (int k = 0; k < N; k++) send(DW'(k + 1), 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < N; k++) send(DW'(3 * (k + 1)), 1'b0, 1'b0, 1'b1);

      // Three frames with random gaps
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < N; k++) begin
            while ($urandom_range(1, 0) == 1) send('0, 1'b0, 1'b0, 1'b0);
            rv = {$urandom, $urandom};
            send(rv, 1'b0, 1'b0, 1'b1);
         end
      end

      // Clear request at channel 100 of the second frame
      for (int k = 0; k < N; k++) send(DW'(k + 7), 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 100; k++) send(DW'(5 * k + 11), 1'b0, 1'b0, 1'b1);
      send(DW'(48'h0ABC), 1'b0, 1'b1, 1'b1);
      wait_clear();
      send(DW'(48'h1234), 1'b0, 1'b0, 1'b1);

      // Out-of-place first marker at channel 50
      for (int k = 1; k < 50; k++) send(DW'(k * 13), 1'b0, 1'b0, 1'b1);
      send(DW'(48'h5555), 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) send(DW'(k + 900), 1'b0, 1'b0, 1'b1);

      // Asynchronous reset with samples in flight
      for (int k = 0; k < 20; k++) send(DW'(k * 1000 + 3), 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      sb_q.delete();
      mdl_reset();
      #1;
      chk_reset_vals("arst");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_clear();
      for (int k = 0; k < 10; k++) send(DW'(k + 77), 1'b0, 1'b0, 1'b1);

      repeat (12) @(negedge clk);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/comb_sched_m256.md
Name: comb_sched_m256

Overview:
Sequencer for the time-multiplexed DSP48 comb stage of the M=256 channelizer. Accepts one sample per channel in round-robin order and keeps a per-channel history RAM holding the previous sample. It presents the current sample on the comb's c input and the previous sample on its concat input with the skew the datapath requires. It tags the returned comb result p with valid and channel index, and handles history clearing at reset and on request.

Parameters:
NUM_CHAN, 256, channels per frame; must be >= 2; channel index width CW = clog2(NUM_CHAN).
DW, 48, sample/history width; matches the comb datapath bus.
C_LAT, 4, cycles from c presented to p valid in the comb datapath.
CAT_LAT, 3, cycles from concat presented to p valid; C_LAT - CAT_LAT must be 1.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-high.
s_valid  in  1  input sample valid.
s_ready  out  1  sampler accepted when s_valid && s_ready.
s_data  in  DW  input sample, channel = internal counter.
s_first  in  1  marks channel 0 (used only with the sync check option).
clr_req  in  1  one-cycle pulse: zero all history.
dsp_c  out  DW  to comb c (current sample).
dsp_concat  out  DW  to comb concat (previous sample of same channel).
p  in  DW  comb result = c - concat.
m_valid  out  1  output valid.
m_chan  out  CW  channel of m_data.
m_data  out  DW  registered copy of p.
busy  out  1  high while clearing.
sync_err  out  1  sticky framing error (optional feature).

Behaviour:
- Reset values: s_ready=0, busy=1, dsp_c=0, dsp_concat=0, m_valid=0, m_chan=0, m_data=0, sync_err=0. Channel counter=0, all valid pipeline bits=0, state=CLEAR with clear address 0.
- FSM CLEAR: s_ready=0, busy=1. Write 0 to hist[clr_addr] each cycle and increment clr_addr. After writing NUM_CHAN-1, go to RUN next cycle. Clearing takes exactly NUM_CHAN cycles.
- FSM RUN: s_ready=1, busy=0. clr_req=1 goes to CLEAR next cycle with clr_addr=0 and chan_cnt=0. A sample accepted in the same cycle as clr_req is still processed.
- clr_req during CLEAR restarts clr_addr at 0.
- Accept at cycle n:
  - read hist[chan_cnt], read-first, registered output;
  - write hist[chan_cnt] = s_data;
  - chan_cnt wraps NUM_CHAN-1 -> 0.
- dsp_c = s_data at cycle n+1. dsp_concat = old hist value at cycle n+2. This is one-cycle skew (C_LAT-CAT_LAT).
- p is valid at cycle n+1+C_LAT = n+5. It is registered to m_data, with m_valid and m_chan asserted at cycle n+6.
- Valid and channel travel in a 6-deep shift register that runs unconditionally. In-flight samples drain normally through CLEAR.
- Gaps in s_valid are allowed. dsp_c and dsp_concat hold their last values; no output is tagged valid for gap cycles.
- No output backpressure; the downstream consumer must always accept.
- Arithmetic is done by the datapath. This block does no width change; all DW bits pass through.
- Reset mid-operation: immediate return to reset values; the whole history is re-cleared.

Optional Feature:
COMB_SCHED_SYNC_CHK_EN.
- Defined: on accept, if s_first != (chan_cnt==0), set sync_err (sticky until rst or clr_req). Force chan_cnt so that the sample is treated as channel 0 if s_first=1, else as current chan_cnt. Then continue from there.
- Undefined: s_first is ignored, sync_err is tied 0, and no check logic is built.

Decomposition:
- Package comb_sched_pkg holds:
  - state enum (CLEAR, RUN);
  - localparams TOTAL_LAT = 1+C_LAT+1;
  - CW function.
- Sub-module comb_hist_ram: simple dual-port NUM_CHAN x DW RAM, read-first, registered read, inferred as BRAM. The FSM, counters and valid pipeline stay in the top level.

Test Plan:
- Reset release -> s_ready low for exactly 256 cycles, busy high; then s_ready=1, busy=0. No m_valid during this time.
- Frame 1 with s_data=k+1 for channel k, then frame 2 with 3(k+1), external comb model -> frame 1 m_data=k+1 and frame 2 m_data=2(k+1). m_chan=k, m_valid 6 cycles after each accept.
- Random s_valid gaps (50% duty) over 3 frames -> output sequence and m_chan identical to the gapless case; no extra m_valid.
- clr_req at channel 100 of frame 2 -> in-flight 6 outputs still emerge. s_ready low for 256 cycles; the next sample is channel 0 and outputs its own value (history 0).
- With COMB_SCHED_SYNC_CHK_EN: s_first asserted at channel 50 -> sync_err=1 next cycle. That sample outputs as channel 0, and the counter continues 1, 2, …
- rst pulse asserted mid-frame, asynchronously between edges -> all outputs reach reset values immediately. Re-clear takes 256 cycles, and no stale m_valid appears afterwards.
